// File: rtl/gesture_classifier.sv
// gesture_classifier: turns per-frame area/perimeter/ratio statistics into a gesture
// code and filters it over several frames. Define GESTURE_HYST_EN for threshold hysteresis.
module gesture_classifier #(
   parameter int unsigned TH_ROCK       = 120,
   parameter int unsigned TH_SCISSORS   = 80,
   parameter int unsigned MIN_AREA      = 2000,
   parameter int unsigned STABLE_FRAMES = 3,
   parameter int unsigned TIMEOUT       = 4096,
   parameter int unsigned HYST          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_end,
   input  logic        ratio_valid,
   input  logic [23:0] ratio,
   input  logic [23:0] area,
   input  logic [23:0] perimeter,
   output logic [1:0]  raw_class,
   output logic [1:0]  gesture,
   output logic        gesture_valid,
   output logic        class_done,
   output logic        timeout_err,
   output logic        busy
);
   localparam int unsigned DW      = 24;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] G_NONE     = 2'd0;
   localparam logic [1:0] G_ROCK     = 2'd1;
   localparam logic [1:0] G_SCISSORS = 2'd2;
   localparam logic [1:0] G_PAPER    = 2'd3;

   localparam logic [DW-1:0]      TH_ROCK_V  = DW'(TH_ROCK);
   localparam logic [DW-1:0]      TH_SC_V    = DW'(TH_SCISSORS);
   localparam logic [DW-1:0]      MIN_AREA_V = DW'(MIN_AREA);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_V   = CNT_W'(STABLE_FRAMES);

   // Elaboration-time guard on the filter depth and hysteresis margin
   if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15 || HYST > 32'h00FF_FFFF) begin : g_param_err
      $error("gesture_classifier: STABLE_FRAMES must be 1..15 and HYST must fit 24 bits");
   end

   typedef enum logic [1:0] {IDLE, WAIT_RATIO, CLASSIFY, FILTER} state_t;

   state_t              state, state_nxt;
   logic [TIMER_W-1:0]  timer, timer_nxt;
   logic [DW-1:0]       lat_ratio, lat_ratio_nxt;
   logic [DW-1:0]       lat_area, lat_area_nxt;
   logic [DW-1:0]       lat_perim, lat_perim_nxt;
   logic                lat_none, lat_none_nxt;
   logic [1:0]          cand, cand_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [1:0]          raw_nxt, gesture_nxt;
   logic                gv_nxt, done_nxt, terr_nxt, busy_nxt;
   logic [DW-1:0]       th_rock, th_sc;
   logic [1:0]          cls;

`ifdef GESTURE_HYST_EN
   localparam logic [DW-1:0] TH_ROCK_LO = (TH_ROCK > HYST) ? DW'(TH_ROCK - HYST) : '0;
   localparam logic [DW-1:0] TH_ROCK_HI = DW'(TH_ROCK + HYST);
   localparam logic [DW-1:0] TH_SC_LO   = (TH_SCISSORS > HYST) ? DW'(TH_SCISSORS - HYST) : '0;
   localparam logic [DW-1:0] TH_SC_HI   = DW'(TH_SCISSORS + HYST);
`endif

   // Frame classification from the latched statistics
   always_comb begin
      th_rock = TH_ROCK_V;
      th_sc   = TH_SC_V;
`ifdef GESTURE_HYST_EN
      case (gesture)
         G_ROCK:     th_rock = TH_ROCK_LO;
         G_SCISSORS: begin
            th_rock = TH_ROCK_HI;
            th_sc   = TH_SC_LO;
         end
         G_PAPER:    th_sc = TH_SC_HI;
         default:    ;
      endcase
`endif
      if (lat_none || lat_perim == '0 || lat_area < MIN_AREA_V) begin
         cls = G_NONE;
      end else if (lat_ratio >= th_rock) begin
         cls = G_ROCK;
      end else if (lat_ratio >= th_sc) begin
         cls = G_SCISSORS;
      end else begin
         cls = G_PAPER;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer;
      lat_ratio_nxt = lat_ratio;
      lat_area_nxt  = lat_area;
      lat_perim_nxt = lat_perim;
      lat_none_nxt  = lat_none;
      cand_nxt      = cand;
      cnt_nxt       = cnt;
      raw_nxt       = raw_class;
      gesture_nxt   = gesture;
      gv_nxt        = 1'b0;
      done_nxt      = 1'b0;
      terr_nxt      = timeout_err;

      case (state)
         IDLE: begin
            if (frame_end) begin
               state_nxt = WAIT_RATIO;
               timer_nxt = '0;
            end
         end
         WAIT_RATIO: begin
            timer_nxt = timer + TIMER_W'(1);
            if (ratio_valid) begin
               lat_ratio_nxt = ratio;
               lat_area_nxt  = area;
               lat_perim_nxt = perimeter;
               lat_none_nxt  = 1'b0;
               state_nxt     = CLASSIFY;
            end else if (timer == TIMER_LAST) begin
               lat_none_nxt = 1'b1;
               terr_nxt     = 1'b1;
               state_nxt    = CLASSIFY;
            end
         end
         CLASSIFY: begin
            raw_nxt   = cls;
            done_nxt  = 1'b1;
            state_nxt = FILTER;
         end
         FILTER: begin
            if (raw_class == cand) begin
               cnt_nxt = (cnt >= STABLE_V) ? STABLE_V : cnt + CNT_W'(1);
            end else begin
               cand_nxt = raw_class;
               cnt_nxt  = CNT_W'(1);
            end
            // Only a confirmed, different class moves the output
            if (cnt_nxt == STABLE_V && cand_nxt != gesture) begin
               gesture_nxt = cand_nxt;
               gv_nxt      = 1'b1;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         lat_ratio     <= '0;
         lat_area      <= '0;
         lat_perim     <= '0;
         lat_none      <= 1'b0;
         cand          <= G_NONE;
         cnt           <= '0;
         raw_class     <= G_NONE;
         gesture       <= G_NONE;
         gesture_valid <= 1'b0;
         class_done    <= 1'b0;
         timeout_err   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         lat_ratio     <= lat_ratio_nxt;
         lat_area      <= lat_area_nxt;
         lat_perim     <= lat_perim_nxt;
         lat_none      <= lat_none_nxt;
         cand          <= cand_nxt;
         cnt           <= cnt_nxt;
         raw_class     <= raw_nxt;
         gesture       <= gesture_nxt;
         gesture_valid <= gv_nxt;
         class_done    <= done_nxt;
         timeout_err   <= terr_nxt;
         busy          <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_gesture_classifier.sv
// Self-checking bench for gesture_classifier: per-frame expectations are queued
// at stimulus time and popped when class_done fires.
module tb_gesture_classifier;
   localparam int unsigned TH_ROCK       = 120;
   localparam int unsigned TH_SCISSORS   = 80;
   localparam int unsigned MIN_AREA      = 2000;
   localparam int unsigned STABLE_FRAMES = 3;
   localparam int unsigned TIMEOUT       = 4096;
   localparam int unsigned HYST          = 8;
   localparam int          LIMIT         = 6000;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_end;
   logic        ratio_valid;
   logic [23:0] ratio;
   logic [23:0] area;
   logic [23:0] perimeter;
   logic [1:0]  raw_class;
   logic [1:0]  gesture;
   logic        gesture_valid;
   logic        class_done;
   logic        timeout_err;
   logic        busy;

   typedef struct {
      logic [1:0] raw;
      logic [1:0] gest;
      logic       gv;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [1:0] m_cand;
   logic [1:0] m_gest;
   int         m_cnt;

   gesture_classifier dut (
      .clk           (clk),
      .rst           (rst),
      .frame_end     (frame_end),
      .ratio_valid   (ratio_valid),
      .ratio         (ratio),
      .area          (area),
      .perimeter     (perimeter),
      .raw_class     (raw_class),
      .gesture       (gesture),
      .gesture_valid (gesture_valid),
      .class_done    (class_done),
      .timeout_err   (timeout_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] model_class(input logic [23:0] r, input logic [23:0] a,
                                              input logic [23:0] p);
      int unsigned th_r, th_s, rr, aa;
      th_r = TH_ROCK;
      th_s = TH_SCISSORS;
      rr   = 32'(r);
      aa   = 32'(a);
`ifdef GESTURE_HYST_EN
      if (m_gest == 2'd1) begin
         th_r = (TH_ROCK > HYST) ? TH_ROCK - HYST : 0;
      end else if (m_gest == 2'd2) begin
         th_r = TH_ROCK + HYST;
         th_s = (TH_SCISSORS > HYST) ? TH_SCISSORS - HYST : 0;
      end else if (m_gest == 2'd3) begin
         th_s = TH_SCISSORS + HYST;
      end
`endif
      if (p == 24'd0 || aa < MIN_AREA) return 2'd0;
      if (rr >= th_r) return 2'd1;
      if (rr >= th_s) return 2'd2;
      return 2'd3;
   endfunction

   task automatic model_reset();
      m_cand = 2'd0;
      m_gest = 2'd0;
      m_cnt  = 0;
      exp_q.delete();
   endtask

   task automatic model_push(input logic [1:0] raw);
      exp_t e;
      e.raw = raw;
      if (raw == m_cand) begin
         if (m_cnt < int'(STABLE_FRAMES)) m_cnt++;
      end else begin
         m_cand = raw;
         m_cnt  = 1;
      end
      e.gv = (m_cnt == int'(STABLE_FRAMES)) && (m_cand != m_gest);
      if (e.gv) m_gest = m_cand;
      e.gest = m_gest;
      exp_q.push_back(e);
   endtask

   // Waits for class_done, then checks the class and the following filter cycle
   task automatic collect(input int exp_lat);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge clk);
         frame_end = 1'b0;
         n++;
      end while (class_done !== 1'b1 && n < LIMIT);
      vectors++;
      if (class_done !== 1'b1) begin
         miscompares++;
         $display("FAIL class_done_wait: no class_done after %0d cycles", n);
         return;
      end
      vectors++;
      if (n != exp_lat) begin
         miscompares++;
         $display("FAIL class_latency: got %0d cycles expected %0d", n, exp_lat);
      end
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: class_done with no queued frame");
         return;
      end
      e = exp_q.pop_front();
      if (raw_class !== e.raw) begin
         miscompares++;
         $display("FAIL raw_class: got %0d expected %0d", raw_class, e.raw);
      end
      @(negedge clk);
      vectors++;
      if (gesture !== e.gest || gesture_valid !== e.gv) begin
         miscompares++;
         $display("FAIL gesture_filter: got gesture=%0d gv=%b expected gesture=%0d gv=%b",
                  gesture, gesture_valid, e.gest, e.gv);
      end
      vectors++;
      if (busy !== 1'b0 || class_done !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_end_state: got busy=%b class_done=%b expected 0 0", busy, class_done);
      end
   endtask

   task automatic run_frame(input logic [23:0] r, input logic [23:0] a, input logic [23:0] p,
                            input int dly, input bit fe_late);
      @(negedge clk);
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_rise: got %b expected 1", busy);
      end
      repeat (dly) @(negedge clk);
      ratio       = r;
      area        = a;
      perimeter   = p;
      ratio_valid = 1'b1;
      model_push(model_class(r, a, p));
      @(negedge clk);
      ratio_valid = 1'b0;
      frame_end   = fe_late;
      collect(1);
   endtask

   task automatic test_reset();
      logic [8:0] outs;
      rst         = 1'b1;
      frame_end   = 1'b0;
      ratio_valid = 1'b0;
      ratio       = '0;
      area        = '0;
      perimeter   = '0;
      repeat (3) @(negedge clk);
      outs = {raw_class, gesture, gesture_valid, class_done, timeout_err, busy, 1'b0};
      vectors++;
      if (outs !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected all zero", outs);
      end
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || class_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: got busy=%b class_done=%b expected 0 0", busy, class_done);
      end
   endtask

   task automatic test_rock();
      for (int i = 0; i < 3; i++) run_frame(24'd150, 24'd5000, 24'd300, i, 1'b0);
      vectors++;
      if (gesture !== 2'd1) begin
         miscompares++;
         $display("FAIL rock_confirm: got %0d expected 1", gesture);
      end
   endtask

   task automatic test_none();
      run_frame(24'd150, 24'd1500, 24'd300, 0, 1'b0);
      run_frame(24'd150, 24'd5000, 24'd0, 1, 1'b0);
      run_frame(24'd60, 24'd9000, 24'd0, 0, 1'b0);
      vectors++;
      if (gesture !== 2'd0) begin
         miscompares++;
         $display("FAIL none_return: got %0d expected 0", gesture);
      end
   endtask

   task automatic test_paper_seq();
      logic [23:0] seq [6];
      seq = '{24'd60, 24'd60, 24'd90, 24'd60, 24'd60, 24'd60};
      for (int i = 0; i < 6; i++) begin
         run_frame(seq[i], 24'd5000, 24'd500, 0, 1'b0);
         if (i == 4) begin
            vectors++;
            if (gesture !== 2'd0) begin
               miscompares++;
               $display("FAIL paper_early: got %0d expected 0", gesture);
            end
         end
      end
      vectors++;
      if (gesture !== 2'd3) begin
         miscompares++;
         $display("FAIL paper_confirm: got %0d expected 3", gesture);
      end
   endtask

   task automatic test_hyst();
      logic [1:0] want;
      for (int i = 0; i < 3; i++) run_frame(24'd150, 24'd5000, 24'd300, 0, 1'b0);
      for (int i = 0; i < 3; i++) run_frame(24'd115, 24'd5000, 24'd300, 0, 1'b0);
`ifdef GESTURE_HYST_EN
      want = 2'd1;
`else
      want = 2'd2;
`endif
      vectors++;
      if (gesture !== want || raw_class !== want) begin
         miscompares++;
         $display("FAIL hyst_115: got gesture=%0d raw=%0d expected %0d", gesture, raw_class, want);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] rtab [11];
      logic [23:0] atab [3];
      logic [23:0] ptab [3];
      rtab = '{24'd0, 24'd75, 24'd79, 24'd80, 24'd85, 24'd115, 24'd119, 24'd120, 24'd121, 24'd125, 24'd200};
      atab = '{24'd1999, 24'd2000, 24'd5000};
      ptab = '{24'd0, 24'd1, 24'd300};
      for (int i = 0; i < 30; i++) begin
         run_frame(rtab[$urandom_range(10)], atab[$urandom_range(2)],
                   (i % 4 == 0) ? ptab[$urandom_range(2)] : 24'd300,
                   int'($urandom_range(3)), 1'($urandom_range(1)));
      end
   endtask

   task automatic test_timeout();
      int seen;
      @(negedge clk);
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
      model_push(2'd0);
      repeat (99) @(negedge clk);
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
      collect(int'(TIMEOUT) + 1 - 100);
      vectors++;
      if (timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_err: got %b expected 1", timeout_err);
      end
      ratio       = 24'd150;
      area        = 24'd5000;
      perimeter   = 24'd300;
      ratio_valid = 1'b1;
      @(negedge clk);
      ratio_valid = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (class_done !== 1'b0 || busy !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL idle_ratio_valid: got %0d active cycles expected 0", seen);
      end
   endtask

   task automatic test_reset_mid();
      int         seen;
      logic [8:0] outs;
      @(negedge clk);
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      model_reset();
      ratio       = 24'd150;
      area        = 24'd5000;
      perimeter   = 24'd300;
      ratio_valid = 1'b1;
      @(negedge clk);
      ratio_valid = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (class_done !== 1'b0 || busy !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL reset_mid_ignored: got %0d active cycles expected 0", seen);
      end
      outs = {raw_class, gesture, gesture_valid, class_done, timeout_err, busy, 1'b0};
      vectors++;
      if (outs !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got %b expected all zero", outs);
      end
      run_frame(24'd150, 24'd5000, 24'd300, 0, 1'b0);
   endtask

   task automatic test_tie();
      run_frame(24'd90, 24'd5000, 24'd500, int'(TIMEOUT) - 1, 1'b0);
      vectors++;
      if (timeout_err !== 1'b0) begin
         miscompares++;
         $display("FAIL tie_timeout_err: got %b expected 0", timeout_err);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_rock();
      test_none();
      test_paper_seq();
      test_hyst();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_tie();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
